// File: rtl/mac_out_pkg.sv
// Shared types and width helpers for the MAC output collector.
package mac_out_pkg;

    localparam int unsigned LANE_W = 16;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH_PUSH,
        ST_FLUSH_DRAIN
    } state_e;

    // Pointer width for an n-entry structure; never narrower than one bit.
    function automatic int unsigned ptr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy width: must represent 0..n inclusive.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mac_out_fifo.sv
// Generic registered FIFO; head is read from storage, never bypassed from the input.
module mac_out_fifo
    import mac_out_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [cnt_bits(DEPTH)-1:0]  o_count
);

    localparam int unsigned PW = ptr_bits(DEPTH);
    localparam int unsigned CW = cnt_bits(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == CW'(DEPTH));
    assign o_count = cnt_q;
    assign o_data  = o_empty ? '0 : mem_q[rd_q];

    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mac_out_collector.sv
// Packs MAC results into PACK-lane words, buffers them and handles end-of-tile flush.
// Optional MAC_OUT_RELU_EN: negative results are stored as zero.
module mac_out_collector
    import mac_out_pkg::*;
#(
    parameter int unsigned PACK  = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [LANE_W-1:0]        i_conv,
    output logic                     o_inhibit,
    input  logic                     i_flush,
    output logic                     o_flush_done,
    output logic                     o_wr_valid,
    input  logic                     i_wr_ready,
    output logic [LANE_W*PACK-1:0]   o_wr_data,
    output logic [PACK-1:0]          o_wr_mask,
    output logic [15:0]              o_word_cnt
);

    localparam int unsigned WW = LANE_W * PACK;
    localparam int unsigned LB = ptr_bits(PACK);
    localparam int unsigned CW = cnt_bits(DEPTH);

    state_e            state_q, state_d;
    logic [LB-1:0]     lane_q, lane_d;
    logic [WW-1:0]     pack_q, pack_d;
    logic              done_q, done_d;
    logic [15:0]       cnt_q;

    logic              accept, push;
    logic [WW-1:0]     push_word;
    logic [PACK-1:0]   push_mask;
    logic [LANE_W-1:0] conv_eff;
    logic [WW+PACK-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt;

`ifdef MAC_OUT_RELU_EN
    assign conv_eff = i_conv[LANE_W-1] ? '0 : i_conv;
`else
    assign conv_eff = i_conv;
`endif

    assign o_inhibit    = (fifo_cnt == CW'(DEPTH)) | (state_q != ST_RUN);
    assign accept       = i_valid & ~o_inhibit;
    assign o_flush_done = done_q;
    assign o_word_cnt   = cnt_q;
    assign o_wr_valid   = ~fifo_empty;
    assign o_wr_data    = fifo_rdata[WW-1:0];
    assign o_wr_mask    = fifo_rdata[WW +: PACK];

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        pack_d    = pack_q;
        done_d    = 1'b0;
        push      = 1'b0;
        push_word = pack_q;
        push_mask = '0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    for (int unsigned k = 0; k < PACK; k++) begin
                        if (LB'(k) == lane_q) pack_d[k*LANE_W +: LANE_W] = conv_eff;
                    end
                    if (lane_q == LB'(PACK - 1)) begin
                        push      = 1'b1;
                        push_word = pack_d;
                        push_mask = '1;
                        pack_d    = '0;
                        lane_d    = '0;
                    end else begin
                        lane_d = lane_q + LB'(1);
                    end
                end
                // Decide on the post-packing lane count so a completing result skips the partial push.
                if (i_flush) begin
                    state_d = (lane_d != '0) ? ST_FLUSH_PUSH : ST_FLUSH_DRAIN;
                end
            end
            ST_FLUSH_PUSH: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = pack_q;
                    for (int unsigned k = 0; k < PACK; k++) begin
                        push_mask[k] = (LB'(k) < lane_q);
                    end
                    pack_d  = '0;
                    lane_d  = '0;
                    state_d = ST_FLUSH_DRAIN;
                end
            end
            ST_FLUSH_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            lane_q  <= '0;
            pack_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            done_q  <= done_d;
            if (push) cnt_q <= cnt_q + 16'd1;
        end
    end

    mac_out_fifo #(
        .WIDTH (WW + PACK),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  ({push_mask, push_word}),
        .i_pop   (i_wr_ready),
        .o_data  (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_cnt)
    );

endmodule

// File: tb/tb_mac_out_collector.sv
// Directed bench for mac_out_collector with a queue-based word model; honours MAC_OUT_RELU_EN.
`timescale 1ns/1ps
module tb_mac_out_collector;

    localparam int unsigned PACK  = 4;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] conv = '0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic        inhibit, flush_done, wr_valid;
    logic [63:0] wr_data;
    logic [3:0]  wr_mask;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    mac_out_collector #(.PACK(PACK), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_conv       (conv),
        .o_inhibit    (inhibit),
        .i_flush      (flush),
        .o_flush_done (flush_done),
        .o_wr_valid   (wr_valid),
        .i_wr_ready   (ready),
        .o_wr_data    (wr_data),
        .o_wr_mask    (wr_mask),
        .o_word_cnt   (word_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Model: results of the current tile, and the words the write-back port must see in order.
    typedef struct { logic [63:0] d; logic [3:0] m; } word_t;
    logic [15:0] pend[$];
    word_t       exp_q[$];
    int          model_words = 0;
    logic [63:0] last_d = '0;
    logic [3:0]  last_m = '0;
    int          done_cnt = 0;
    bit          inh_seen = 0;

    function automatic logic [15:0] stored(input logic [15:0] v);
`ifdef MAC_OUT_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic emit();
        word_t w;
        w.d = '0;
        w.m = '0;
        foreach (pend[k]) begin
            w.d[k*16 +: 16] = pend[k];
            w.m[k] = 1'b1;
        end
        exp_q.push_back(w);
        pend.delete();
        model_words++;
    endtask

    task automatic model_accept(input logic [15:0] v);
        pend.push_back(stored(v));
        if (pend.size() == PACK) emit();
    endtask

    task automatic model_flush();
        if (pend.size() > 0) emit();
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        model_words = 0;
    endtask

    // Compare process: every handshake beat is checked against the model queue.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (inhibit) inh_seen = 1;
            if (flush_done) done_cnt++;
            if (wr_valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected word", wr_data, 64'd0);
                end else begin
                    chk("word data", wr_data, exp_q[0].d);
                    chk("word mask", 64'(wr_mask), 64'(exp_q[0].m));
                    void'(exp_q.pop_front());
                end
                last_d = wr_data;
                last_m = wr_mask;
            end
        end
    end

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] v, input logic fl);
        int unsigned n = 0;
        valid = 1'b1;
        conv  = v;
        while (inhibit && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("accept timeout", 64'(inhibit), 64'd0);
        end else begin
            flush = fl;
            model_accept(v);
            if (fl) model_flush();
        end
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        model_flush();
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || wr_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain timeout", 64'(n < 200), 64'd1);
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (!flush_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("flush_done seen", 64'(flush_done), 64'd1);
        chk("fifo empty at done", 64'(wr_valid), 64'd0);
        @(negedge clk);
        chk("flush_done one cycle", 64'(flush_done), 64'd0);
        chk("inhibit after flush", 64'(inhibit), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        int  d0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst inhibit", 64'(inhibit), 64'd0);
        chk("rst flush_done", 64'(flush_done), 64'd0);
        chk("rst wr_valid", 64'(wr_valid), 64'd0);
        chk("rst wr_data", wr_data, 64'd0);
        chk("rst wr_mask", 64'(wr_mask), 64'd0);
        chk("rst word_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Streaming with write-back always ready
        ready = 1'b1;
        inh_seen = 0;
        t0 = $time;
        for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
        chk("throughput cycles", 64'(($time - t0) / 10), 64'd8);
        wait_drain();
        chk("t1 last word", last_d, 64'h0008_0007_0006_0005);
        chk("t1 last mask", 64'(last_m), 64'hF);
        chk("t1 word_cnt", 64'(word_cnt), 64'd2);
        chk("t1 no inhibit", 64'(inh_seen), 64'd0);

        // Backpressure: fill FIFO, hold result 33 across the stall
        ready = 1'b0;
        for (int i = 1; i <= 31; i++) send(16'(16'h0100 + i), 1'b0);
        chk("inhibit before 8th push", 64'(inhibit), 64'd0);
        send(16'h0120, 1'b0);
        chk("inhibit after 8th push", 64'(inhibit), 64'd1);
        fork
            send(16'h0121, 1'b0);
            begin
                repeat (10) @(negedge clk);
                chk("inhibit held full", 64'(inhibit), 64'd1);
                chk("t2 word_cnt full", 64'(word_cnt), 64'd10);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                chk("inhibit clears after pop", 64'(inhibit), 64'd0);
                chk("t2 first word", last_d, 64'h0104_0103_0102_0101);
            end
        join
        ready = 1'b1;
        for (int i = 34; i <= 36; i++) send(16'(16'h0100 + i), 1'b0);
        wait_drain();
        chk("t2 held accepted once", last_d, 64'h0124_0123_0122_0121);
        chk("t2 word_cnt", 64'(word_cnt), 64'(model_words));
        chk("t2 word_cnt lit", 64'(word_cnt), 64'd11);

        // Partial flush
        send(16'h0011, 1'b0);
        send(16'h0022, 1'b0);
        send(16'h0033, 1'b0);
        flush_only();
        wait_drain();
        wait_done();
        chk("t3 partial word", last_d, 64'h0000_0033_0022_0011);
        chk("t3 partial mask", 64'(last_m), 64'h7);
        chk("t3 word_cnt", 64'(word_cnt), 64'd12);

        // Flush coinciding with the 4th lane
        send(16'h0041, 1'b0);
        send(16'h0042, 1'b0);
        send(16'h0043, 1'b0);
        send(16'h0044, 1'b1);
        wait_drain();
        wait_done();
        chk("t4 full word", last_d, 64'h0044_0043_0042_0041);
        chk("t4 full mask", 64'(last_m), 64'hF);
        chk("t4 no extra push", 64'(word_cnt), 64'd13);

        // Reset during FLUSH_DRAIN with 3 words queued
        ready = 1'b0;
        for (int i = 0; i < 12; i++) send(16'(16'h0200 + i), 1'b0);
        flush_only();
        repeat (3) @(negedge clk);
        chk("t5 draining inhibit", 64'(inhibit), 64'd1);
        chk("t5 word_cnt", 64'(word_cnt), 64'd16);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("t5 wr_valid", 64'(wr_valid), 64'd0);
        chk("t5 word_cnt cleared", 64'(word_cnt), 64'd0);
        chk("t5 inhibit", 64'(inhibit), 64'd0);
        chk("t5 flush_done", 64'(flush_done), 64'd0);
        d0 = done_cnt;
        ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5 no done pulse", 64'(done_cnt), 64'(d0));
        chk("t5 still empty", 64'(wr_valid), 64'd0);

        // Sign handling
        send(16'h8123, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h8000, 1'b0);
        send(16'h0001, 1'b0);
        wait_drain();
`ifdef MAC_OUT_RELU_EN
        chk("t6 relu word", last_d, 64'h0001_0000_4000_0000);
`else
        chk("t6 exact word", last_d, 64'h0001_8000_4000_8123);
`endif
        chk("t6 mask", 64'(last_m), 64'hF);
        chk("t6 word_cnt", 64'(word_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_out_collector.md
Name: mac_out_collector

Overview:
- Downstream receiver of the MAC pipeline's final-stage result stream (valid + 16-bit conv result, inhibit backpressure).
- Packs consecutive 16-bit results into PACK-lane words and buffers them in a FIFO.
- Drives the write-back port with a valid/ready handshake.
- Generates the pipeline-wide inhibit when it cannot accept, and supports an end-of-tile flush with a partial-word lane mask.

Parameters:
- PACK, 4, number of 16-bit lanes per output word (power of 2, 2..8).
- DEPTH, 8, FIFO depth in packed words (power of 2, >=2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. Synchronous, active-high.
- i_valid  in  1  MAC result valid.
- i_conv  in  16  MAC result, FloatSD 16-bit format, bit 15 = sign.
- o_inhibit  out  1  stall to the MAC pipeline. While high, upstream holds i_valid/i_conv unchanged.
- i_flush  in  1  single-cycle pulse: end of tile.
- o_flush_done  out  1  single-cycle pulse: flush complete.
- o_wr_valid  out  1  FIFO head valid.
- i_wr_ready  in  1  write-back accepts the head.
- o_wr_data  out  16*PACK  packed word. Lane k = bits [16k+15:16k]; lane 0 = earliest result.
- o_wr_mask  out  PACK  per-lane valid mask.
- o_word_cnt  out  16  packed words pushed since reset. Wraps at 2^16.

Behaviour:
- Reset (synchronous, i_rst=1 at posedge): o_inhibit=0, o_flush_done=0, o_wr_valid=0, o_wr_data=0, o_wr_mask=0, o_word_cnt=0, lane counter=0, FIFO empty, state=RUN. Reset mid-flush or with a non-empty FIFO discards all contents.
- Accept rule: a result is consumed on a cycle with i_valid=1 and o_inhibit=0. With o_inhibit=1, the repeated held value is never consumed twice.
- Packer: the accepted result is written into lane[lane_cnt], then lane_cnt increments.
  - When lane_cnt reaches PACK-1 and a result is accepted, the full word is pushed to the FIFO with mask all-ones, lane_cnt returns to 0, and the packing register clears.
- FIFO: a push at edge N is visible on o_wr_data/o_wr_valid after edge N (read from registered storage, no combinational input-to-output path).
  - Pop occurs when o_wr_valid & i_wr_ready.
  - Simultaneous push and pop is legal at any non-empty occupancy, and the count is unchanged.
  - Pointers wrap modulo DEPTH. Occupancy is held in clog2(DEPTH)+1 bits.
- o_inhibit = (fifo_count==DEPTH) | (state!=RUN). It is decoded from registers only.
  - A pop while full does not deassert inhibit in that same cycle; inhibit clears the next cycle.
- o_word_cnt increments by 1 on every push, full or partial.
- State machine:
  - RUN: normal operation. On i_flush, the same-cycle accepted result (if any) is packed first. Then:
    - lane_cnt after packing >0: go to FLUSH_PUSH.
    - otherwise: go to FLUSH_DRAIN.
  - FLUSH_PUSH: push the partial word as soon as FIFO is not full. Unused lanes are 0 and the mask has the low lane_cnt bits set. Then clear lane_cnt and go to FLUSH_DRAIN.
  - FLUSH_DRAIN: wait for FIFO empty. Then pulse o_flush_done for one cycle and return to RUN.
  - i_flush while not in RUN is ignored.
- Back-to-back throughput: 1 result/cycle sustained when i_wr_ready=1 continuously.

Optional Feature:
- Macro MAC_OUT_RELU_EN.
- Defined: every accepted result with i_conv[15]=1 is stored as 16'h0000 (ReLU). Positive values and +0 are stored unchanged. Lane mask is unaffected.
- Undefined: results are stored bit-exact.

Decomposition:
- Shared package mac_out_pkg:
  - LANE_W=16.
  - State encoding typedef (RUN, FLUSH_PUSH, FLUSH_DRAIN).
  - Localparam helpers for clog2-derived pointer and count widths.
- One sub-module: mac_out_fifo. A generic registered FIFO with push/pop/full/empty/count, parameterised by width and DEPTH.
- Packer, FSM and inhibit logic live in mac_out_collector.

Test Plan:
- Stream 0x0001..0x0008 (PACK=4), i_wr_ready=1 -> two words: 0x0004_0003_0002_0001 then 0x0008_0007_0006_0005, mask 4'b1111, o_word_cnt=2, o_inhibit never high.
- i_wr_ready=0, stream 32 results with DEPTH=8 -> o_inhibit rises on the cycle after the 8th push. Upstream holds result #33 for many cycles, and it is accepted exactly once after one pop. Data order is preserved.
- Send 0x0011, 0x0022, 0x0033, then i_flush -> partial word 0x0000_0033_0022_0011, mask 4'b0111. o_flush_done pulses one cycle after the FIFO drains.
- i_flush on the same cycle as an accepted 4th lane -> full word with mask 4'b1111 and no extra partial push. State goes straight to FLUSH_DRAIN.
- Assert i_rst during FLUSH_DRAIN with 3 words queued -> next cycle o_wr_valid=0, o_word_cnt=0, o_inhibit=0, and no o_flush_done pulse.
- MAC_OUT_RELU_EN defined: inputs 0x8123, 0x4000, 0x8000, 0x0001 -> word 0x0001_0000_4000_0000. Undefined: word 0x0001_8000_4000_8123.
